// File: rtl/shared_mem_responder_pkg.sv
// rtl/shared_mem_responder_pkg.sv - shared definitions for the shared memory responder
// Enable encodings match the core side; SHARED_MEM_ERR_CHECK_EN changes how 2'b11 decodes.
package shared_mem_responder_pkg;

    localparam int DEF_NUM_CORES    = 16;
    localparam int DEF_REG_SIZE     = 8;
    localparam int DEF_CORE_ID_SIZE = 4;
    localparam int DEF_ACCESS_LAT   = 2;

    typedef logic [1:0] mem_en_t;

    localparam mem_en_t MEM_EN_IDLE = 2'b00;
    localparam mem_en_t MEM_EN_LD   = 2'b01;
    localparam mem_en_t MEM_EN_ST   = 2'b10;
    localparam mem_en_t MEM_EN_ILL  = 2'b11;

    typedef enum logic [1:0] {
        OP_LD  = 2'd0,
        OP_ST  = 2'd1,
        OP_ILL = 2'd2
    } op_e;

    // Without error checking the illegal encoding falls back to a plain load.
    function automatic op_e decode_en(input mem_en_t en);
        op_e op;
        op = OP_LD;
        if (en == MEM_EN_ST) begin
            op = OP_ST;
        end
`ifdef SHARED_MEM_ERR_CHECK_EN
        if (en == MEM_EN_ILL) begin
            op = OP_ILL;
        end
`endif
        return op;
    endfunction

endpackage

// File: rtl/shared_mem_responder_rr_arbiter.sv
// rtl/shared_mem_responder_rr_arbiter.sv - combinational round-robin arbiter
// Picks the first asserted request at or after ptr, wrapping modulo N.
module shared_mem_responder_rr_arbiter #(
    parameter int N    = 16,
    parameter int IDXW = 4
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_valid
);

    localparam int SW = IDXW + 1;

    logic [SW-1:0]   sum;
    logic [IDXW-1:0] idx;

    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + SW'(k);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            idx = sum[IDXW-1:0];
            if (req[idx]) begin
                grant_idx   = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_mem_responder.sv
// rtl/shared_mem_responder.sv - shared single-port data RAM serving NUM_CORES cores round-robin
// Optional illegal-enable detection via SHARED_MEM_ERR_CHECK_EN.
module shared_mem_responder
    import shared_mem_responder_pkg::*;
#(
    parameter int NUM_CORES    = DEF_NUM_CORES,
    parameter int REG_SIZE     = DEF_REG_SIZE,
    parameter int CORE_ID_SIZE = DEF_CORE_ID_SIZE,
    parameter int ACCESS_LAT   = DEF_ACCESS_LAT
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic [2*NUM_CORES-1:0]                       enable,
    input  logic [(CORE_ID_SIZE+REG_SIZE)*NUM_CORES-1:0] addr,
    input  logic [REG_SIZE*NUM_CORES-1:0]                wr_data,
    output logic [REG_SIZE*NUM_CORES-1:0]                rd_data,
    output logic [NUM_CORES-1:0]                         ready_sig,
    output logic                                         err,
    output logic [CORE_ID_SIZE-1:0]                      err_core
);

    localparam int ADDR_SIZE = CORE_ID_SIZE + REG_SIZE;
    localparam int DEPTH     = 2 ** ADDR_SIZE;
    localparam int IDXW      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [IDXW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]      grant_q, grant_d;
    op_e                  op_q, op_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [REG_SIZE-1:0]  wdata_q, wdata_d;
    logic [REG_SIZE-1:0]  rdata_q, rdata_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [NUM_CORES-1:0] ready_q, ready_d;

    logic [NUM_CORES-1:0] req;
    logic [IDXW-1:0]      arb_idx;
    logic                 arb_valid;
    mem_en_t              sel_en;
    logic [ADDR_SIZE-1:0] sel_addr;
    logic [REG_SIZE-1:0]  sel_wdata;
    logic                 last_cycle;
    logic                 mem_we;

    logic [REG_SIZE-1:0]  mem [DEPTH];

    always_comb begin
        req       = '0;
        sel_en    = MEM_EN_IDLE;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            req[i] = (enable[2*i +: 2] != MEM_EN_IDLE);
            if (arb_idx == IDXW'(i)) begin
                sel_en    = enable[2*i +: 2];
                sel_addr  = addr[ADDR_SIZE*i +: ADDR_SIZE];
                sel_wdata = wr_data[REG_SIZE*i +: REG_SIZE];
            end
        end
    end

    shared_mem_responder_rr_arbiter #(
        .N    (NUM_CORES),
        .IDXW (IDXW)
    ) u_arb (
        .req         (req),
        .ptr         (rr_ptr_q),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    assign last_cycle = (state_q == ST_BUSY) && (cnt_q == 4'd0);
    assign mem_we     = last_cycle && (op_q == OP_ST);

    // Arbitration only happens in IDLE; RESP gives the served core one edge to drop or change its request.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        ready_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_idx;
                    op_d    = decode_en(sel_en);
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    cnt_d   = 4'(ACCESS_LAT - 1);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d          = ST_RESP;
                    ready_d[grant_q] = 1'b1;
                    case (op_q)
                        OP_LD:   rdata_d = mem[addr_q];
                        OP_ILL:  rdata_d = '0;
                        default: rdata_d = rdata_q;
                    endcase
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                rr_ptr_d = (grant_q == IDXW'(NUM_CORES - 1)) ? '0 : grant_q + 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            op_q     <= OP_LD;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            ready_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
        end
    end

    // Reset drops state_q to IDLE asynchronously, which is what suppresses an in-flight write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign rd_data   = {NUM_CORES{rdata_q}};
    assign ready_sig = ready_q;

`ifdef SHARED_MEM_ERR_CHECK_EN
    logic                    err_q, err_d;
    logic [CORE_ID_SIZE-1:0] err_core_q, err_core_d;

    always_comb begin
        err_d      = err_q;
        err_core_d = err_core_q;
        if (last_cycle && (op_q == OP_ILL) && !err_q) begin
            err_d      = 1'b1;
            err_core_d = CORE_ID_SIZE'(grant_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q      <= 1'b0;
            err_core_q <= '0;
        end else begin
            err_q      <= err_d;
            err_core_q <= err_core_d;
        end
    end

    assign err      = err_q;
    assign err_core = err_core_q;
`else
    assign err      = 1'b0;
    assign err_core = '0;
`endif

endmodule

// File: tb/tb_shared_mem_responder.sv
// tb/tb_shared_mem_responder.sv - directed table-driven bench for shared_mem_responder
module tb_shared_mem_responder;

    localparam int NC  = 16;
    localparam int RS  = 8;
    localparam int CS  = 4;
    localparam int AS  = CS + RS;
    localparam int LAT = 2;
    localparam int NV  = 12;
`ifdef SHARED_MEM_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic [2*NC-1:0] enable;
    logic [AS*NC-1:0] addr;
    logic [RS*NC-1:0] wr_data;
    logic [RS*NC-1:0] rd_data;
    logic [NC-1:0]   ready_sig;
    logic            err;
    logic [CS-1:0]   err_core;

    shared_mem_responder #(
        .NUM_CORES    (NC),
        .REG_SIZE     (RS),
        .CORE_ID_SIZE (CS),
        .ACCESS_LAT   (LAT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .addr      (addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .ready_sig (ready_sig),
        .err       (err),
        .err_core  (err_core)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          core;
        logic [1:0]  en;
        logic [11:0] a;
        logic [7:0]  wd;
        bit          chk;
        logic [7:0]  exp;
        logic        eerr;
        logic [3:0]  ecore;
    } vec_t;

    vec_t       vecs [NV];
    int         compared = 0;
    int         mismatched = 0;
    int         first_t [NC];
    int         pulses  [NC];
    logic [7:0] data_at [NC];

    function automatic vec_t mkv(input int c, input logic [1:0] en, input logic [11:0] a,
                                 input logic [7:0] wd, input bit chk, input logic [7:0] exp,
                                 input logic eerr, input logic [3:0] ecore);
        vec_t v;
        v.core = c; v.en = en; v.a = a; v.wd = wd;
        v.chk = chk; v.exp = exp; v.eerr = eerr; v.ecore = ecore;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic set_req(input int c, input logic [1:0] en, input logic [11:0] a, input logic [7:0] wd);
        enable[2*c +: 2]   = en;
        addr[AS*c +: AS]   = a;
        wr_data[RS*c +: RS] = wd;
    endtask

    function automatic logic [7:0] rd_slice(input int c);
        return rd_data[RS*c +: RS];
    endfunction

    task automatic wait_ready(input int c, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_sig[c] && n < 40);
    endtask

    // Observes ncyc cycles; a core drops its request on its own ready pulse.
    task automatic watch(input int ncyc);
        for (int i = 0; i < NC; i++) begin
            first_t[i] = -1; pulses[i] = 0; data_at[i] = 8'h00;
        end
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            for (int i = 0; i < NC; i++) begin
                if (ready_sig[i]) begin
                    pulses[i]++;
                    if (first_t[i] < 0) begin
                        first_t[i] = c;
                        data_at[i] = rd_slice(i);
                    end
                    enable[2*i +: 2] = 2'b00;
                end
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable  = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int n;
        int total;

        vecs[0]  = mkv(3,  2'b10, 12'h310, 8'hA5, 0, 8'h00, 0, 0);
        vecs[1]  = mkv(3,  2'b01, 12'h310, 8'h00, 1, 8'hA5, 0, 0);
        vecs[2]  = mkv(0,  2'b10, 12'h720, 8'h3C, 0, 8'h00, 0, 0);
        vecs[3]  = mkv(7,  2'b01, 12'h720, 8'h00, 1, 8'h3C, 0, 0);
        vecs[4]  = mkv(0,  2'b10, 12'h001, 8'h5A, 0, 8'h00, 0, 0);
        vecs[5]  = mkv(0,  2'b10, 12'h002, 8'h6B, 0, 8'h00, 0, 0);
        vecs[6]  = mkv(2,  2'b10, 12'h204, 8'h11, 0, 8'h00, 0, 0);
        vecs[7]  = mkv(4,  2'b10, 12'h408, 8'h77, 0, 8'h00, 0, 0);
        vecs[8]  = mkv(4,  2'b11, 12'h408, 8'h00, 1, ERR_EN ? 8'h00 : 8'h77, ERR_EN, ERR_EN ? 4'd4 : 4'd0);
        vecs[9]  = mkv(9,  2'b10, 12'h9FF, 8'h99, 0, 8'h00, ERR_EN, ERR_EN ? 4'd4 : 4'd0);
        vecs[10] = mkv(9,  2'b11, 12'h9FF, 8'h00, 1, ERR_EN ? 8'h00 : 8'h99, ERR_EN, ERR_EN ? 4'd4 : 4'd0);
        vecs[11] = mkv(15, 2'b01, 12'h9FF, 8'h00, 1, 8'h99, ERR_EN, ERR_EN ? 4'd4 : 4'd0);

        enable = '0; addr = '0; wr_data = '0; reset_n = 1'b1;
        @(negedge clk);
        do_reset();
        check("rst_ready", ready_sig, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_err", err, 0);
        check("rst_err_core", err_core, 0);

        for (int v = 0; v < NV; v++) begin
            set_req(vecs[v].core, vecs[v].en, vecs[v].a, vecs[v].wd);
            wait_ready(vecs[v].core, n);
            check($sformatf("v%0d_latency", v), n, LAT + 1);
            check($sformatf("v%0d_onehot", v), ready_sig, 128'(1) << vecs[v].core);
            if (vecs[v].chk) begin
                check($sformatf("v%0d_rd_data", v), rd_slice(vecs[v].core), vecs[v].exp);
            end
            check($sformatf("v%0d_err", v), err, vecs[v].eerr);
            check($sformatf("v%0d_err_core", v), err_core, vecs[v].ecore);
            set_req(vecs[v].core, 2'b00, vecs[v].a, 8'h00);
            @(negedge clk);
            check($sformatf("v%0d_pulse_end", v), ready_sig, 0);
        end

        // Core 0 holds LD across two addresses: exactly two serves.
        set_req(0, 2'b01, 12'h001, 8'h00);
        wait_ready(0, n);
        check("b2b_lat1", n, LAT + 1);
        check("b2b_data1", rd_slice(0), 8'h5A);
        set_req(0, 2'b01, 12'h002, 8'h00);
        wait_ready(0, n);
        check("b2b_lat2", n, LAT + 2);
        check("b2b_data2", rd_slice(0), 8'h6B);
        set_req(0, 2'b00, 12'h000, 8'h00);
        watch(10);
        check("b2b_no_extra", pulses[0], 0);
        check("err_sticky", err, ERR_EN);
        check("err_core_sticky", err_core, ERR_EN ? 4'd4 : 4'd0);

        do_reset();
        check("rst2_err", err, 0);
        check("rst2_err_core", err_core, 0);

        // Simultaneous requests after reset are served 0,1,2.
        set_req(0, 2'b01, 12'h001, 8'h00);
        set_req(1, 2'b01, 12'h002, 8'h00);
        set_req(2, 2'b01, 12'h310, 8'h00);
        watch(14);
        check("rr_t0", first_t[0], LAT + 1);
        check("rr_t1", first_t[1], 2 * LAT + 3);
        check("rr_t2", first_t[2], 3 * LAT + 5);
        check("rr_n0", pulses[0], 1);
        check("rr_n1", pulses[1], 1);
        check("rr_n2", pulses[2], 1);
        check("rr_d0", data_at[0], 8'h5A);
        check("rr_d1", data_at[1], 8'h6B);
        check("rr_d2", data_at[2], 8'hA5);

        set_req(1, 2'b01, 12'h001, 8'h00);
        set_req(5, 2'b01, 12'h310, 8'h00);
        watch(10);
        check("rr_ptr3_t5", first_t[5], LAT + 1);
        check("rr_ptr3_t1", first_t[1], 2 * LAT + 3);
        check("rr_ptr3_d5", data_at[5], 8'hA5);
        check("rr_ptr3_d1", data_at[1], 8'h5A);

        // Reset during BUSY of a store aborts it.
        set_req(2, 2'b10, 12'h204, 8'h55);
        @(negedge clk);
        reset_n = 1'b0;
        set_req(2, 2'b00, 12'h204, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        watch(8);
        total = 0;
        for (int i = 0; i < NC; i++) total += pulses[i];
        check("abort_no_ready", total, 0);
        check("abort_rd_data", rd_data, 0);

        set_req(0, 2'b01, 12'h001, 8'h00);
        set_req(15, 2'b01, 12'h204, 8'h00);
        watch(10);
        check("abort_ptr_t0", first_t[0], LAT + 1);
        check("abort_ptr_t15", first_t[15], 2 * LAT + 3);
        check("abort_old_data", data_at[15], 8'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
